countdown_timer_ctrl: RTL

//   mm:ss countdown timer controller driven by clock_div clock-enables (ce_1hz, ce_2hz).

---
 rtl/timer_pkg.sv | 30 +++
 rtl/bcd_mmss_counter.sv | 79 +++++++
 rtl/countdown_timer_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and helpers for the mm:ss countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} tmr_state_t;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
  } bcd_mmss_t;

  localparam bcd_mmss_t BCD_ZERO = '0;
  localparam bcd_mmss_t BCD_ONE  = bcd_mmss_t'(16'h0001);

  // Elaboration-time conversion of a seconds count to mm:ss BCD.
  function automatic bcd_mmss_t sec_to_bcd(input int unsigned s);
    int unsigned m;
    int unsigned r;
    bcd_mmss_t b;
    m    = s / 60;
    r    = s % 60;
    b.mt = 4'(m / 10);
    b.mo = 4'(m % 10);
    b.st = 4'(r / 10);
    b.so = 4'(r % 10);
    return b;
  endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// mm:ss BCD register with load, independent minute/second increment and
// borrowing decrement. Priority: load > dec > inc.
module bcd_mmss_counter
  import timer_pkg::*;
#(
  parameter int        MAX_MIN = 99,
  parameter bcd_mmss_t RST_VAL = '0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  bcd_mmss_t load_val,
  input  logic      inc_m,
  input  logic      inc_s,
  input  logic      dec,
  output bcd_mmss_t value,
  output logic      zero
);

  localparam logic [3:0] MAX_MT = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MO = 4'(MAX_MIN % 10);

  bcd_mmss_t nxt;

  assign zero = (value == BCD_ZERO);

  always_comb begin
    nxt = value;
    if (load) begin
      nxt = load_val;
    end else if (dec) begin
      // Decrement at 00:00 holds rather than wrapping to an illegal value.
      if (!zero) begin
        if (value.so != 4'd0) begin
          nxt.so = value.so - 4'd1;
        end else begin
          nxt.so = 4'd9;
          if (value.st != 4'd0) begin
            nxt.st = value.st - 4'd1;
          end else begin
            nxt.st = 4'd5;
            if (value.mo != 4'd0) begin
              nxt.mo = value.mo - 4'd1;
            end else begin
              nxt.mo = 4'd9;
              nxt.mt = value.mt - 4'd1;
            end
          end
        end
      end
    end else begin
      if (inc_s) begin
        if (value.so != 4'd9) begin
          nxt.so = value.so + 4'd1;
        end else begin
          nxt.so = 4'd0;
          nxt.st = (value.st == 4'd5) ? 4'd0 : value.st + 4'd1;
        end
      end
      if (inc_m) begin
        if (value.mt == MAX_MT && value.mo == MAX_MO) begin
          nxt.mt = 4'd0;
          nxt.mo = 4'd0;
        end else if (value.mo == 4'd9) begin
          nxt.mo = 4'd0;
          nxt.mt = value.mt + 4'd1;
        end else begin
          nxt.mo = value.mo + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) value <= RST_VAL;
    else     value <= nxt;
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// mm:ss countdown timer: IDLE/RUN/PAUSE/ALARM sequencing around a BCD counter,
// driven by debounced button pulses and 1 Hz / 2 Hz clock enables.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int MAX_MIN     = 99,
  parameter int DEFAULT_SEC = 60,
  parameter int ALARM_SEC   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_1hz,
  input  logic        ce_2hz,
  input  logic        btn_start,
  input  logic        btn_stop,
  input  logic        btn_clear,
  input  logic        btn_inc_m,
  input  logic        btn_inc_s,
  output logic [15:0] digits,
  output logic        running,
  output logic        alarm,
  output logic        blank
);

  localparam bcd_mmss_t DEFAULT_BCD = sec_to_bcd(DEFAULT_SEC);
  localparam int        CW          = $clog2(ALARM_SEC + 1);
  localparam logic [CW-1:0] ALARM_LAST = CW'(ALARM_SEC - 1);

  tmr_state_t    state;
  bcd_mmss_t     preset;
  bcd_mmss_t     value;
  logic [CW-1:0] alarm_cnt;
  logic          zero;
  logic          ld, cnt_inc_m, cnt_inc_s, cnt_dec;
  bcd_mmss_t     ld_val;
  logic          ack, alarm_done;

  assign ack        = btn_start | btn_stop | btn_clear;
  assign alarm_done = ce_1hz && (alarm_cnt == ALARM_LAST);
  assign digits     = value;

  // Counter commands follow the button priority; anything shadowed is dropped.
  always_comb begin
    ld        = 1'b0;
    ld_val    = BCD_ZERO;
    cnt_inc_m = 1'b0;
    cnt_inc_s = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (btn_clear) ld = 1'b1;
        else if (!(btn_start && !zero)) begin
          cnt_inc_m = btn_inc_m;
          cnt_inc_s = btn_inc_s;
        end
      end
      RUN: begin
        if (btn_clear) ld = 1'b1;
        else if (!btn_stop) cnt_dec = ce_1hz;
      end
      PAUSE: ld = btn_clear;
      ALARM: begin
        if (ack || alarm_done) begin
          ld     = 1'b1;
          ld_val = preset;
        end
      end
      default: ;
    endcase
  end

  bcd_mmss_counter #(
    .MAX_MIN (MAX_MIN),
    .RST_VAL (DEFAULT_BCD)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (ld_val),
    .inc_m    (cnt_inc_m),
    .inc_s    (cnt_inc_s),
    .dec      (cnt_dec),
    .value    (value),
    .zero     (zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      preset    <= DEFAULT_BCD;
      running   <= 1'b0;
      alarm     <= 1'b0;
      blank     <= 1'b0;
      alarm_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!btn_clear && btn_start && !zero) begin
            preset  <= value;
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (btn_clear) begin
            state   <= IDLE;
            running <= 1'b0;
          end else if (btn_stop) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (ce_1hz && value == BCD_ONE) begin
            // The decrement that hits 00:00 lands us in ALARM in the same cycle.
            state     <= ALARM;
            running   <= 1'b0;
            alarm     <= 1'b1;
            blank     <= 1'b0;
            alarm_cnt <= '0;
          end
        end
        PAUSE: begin
          if (btn_clear) begin
            state <= IDLE;
          end else if (btn_start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        ALARM: begin
          if (ack || alarm_done) begin
            state     <= IDLE;
            alarm     <= 1'b0;
            blank     <= 1'b0;
            alarm_cnt <= '0;
          end else begin
            if (ce_1hz) alarm_cnt <= alarm_cnt + 1'b1;
            if (ce_2hz) blank <= ~blank;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
